// File: rtl/fp_multiplier_param.sv
// Parametrised multi-cycle IEEE-754 binary multiplier with valid/ready handshake,
// four rounding modes and {invalid, overflow, underflow, inexact} exception flags.
module fp_multiplier_param #(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+FRAC_W:0] a,
  input  logic [EXP_W+FRAC_W:0] b,
  input  logic [1:0]            rnd_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+FRAC_W:0] z,
  output logic [3:0]            flags
);
  localparam int W    = 1 + EXP_W + FRAC_W;
  localparam int M    = FRAC_W + 1;
  localparam int EW   = EXP_W + 3;
  localparam int BIAS = 2**(EXP_W-1) - 1;
  localparam int LIM  = FRAC_W + 3;
  localparam int CW   = $clog2(LIM + 1);
  localparam logic signed [EW-1:0] BIAS_E = EW'(BIAS);
  localparam logic signed [EW-1:0] EMIN_E = EW'(1 - BIAS);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_UNPACK = 4'd1, S_SPECIAL = 4'd2, S_NORM = 4'd3, S_MULT = 4'd4,
    S_NORM_Z = 4'd5, S_DENORM = 4'd6, S_ROUND = 4'd7, S_PACK = 4'd8, S_DONE = 4'd9
  } state_t;

  // Unbiased exponent; subnormals sit at EMIN with a clear hidden bit.
  function automatic logic signed [EW-1:0] unb_exp(input logic [EXP_W-1:0] ef);
    if (ef == {EXP_W{1'b0}}) unb_exp = EMIN_E;
    else                     unb_exp = $signed({3'b000, ef}) - BIAS_E;
  endfunction

  state_t                state_q;
  logic                  in_ready_q, out_valid_q;
  logic [W-1:0]          z_q, a_q, b_q;
  logic [3:0]            flags_q;
  logic [1:0]            rm_q;
  logic                  sign_q, a_zero_q, a_inf_q, a_nan_q, b_zero_q, b_inf_q, b_nan_q;
  logic [M-1:0]          ma_q, mb_q, mant_q;
  logic signed [EW-1:0]  ea_q, eb_q, e_q;
  logic [2*M-1:0]        prod_q;
  logic                  g_q, r_q, s_q, tiny_q, inexact_q;
  logic [CW-1:0]         cnt_q;

  logic [EXP_W-1:0]      exp_a_s, exp_b_s, exp_field_s;
  logic [FRAC_W-1:0]     frac_a_s, frac_b_s;
  logic                  a_ez_s, a_eo_s, a_fz_s, b_ez_s, b_eo_s, b_fz_s;
  logic [2*M-1:0]        pn_s;
  logic signed [EW-1:0]  en_s, e_inc_s;
  logic                  tiny_s, any_s, inc_s, ovf_s;
  logic [M:0]            sum_s;
  logic [W-1:0]          inf_s, max_s, ovf_z_s;

  assign exp_a_s  = a_q[W-2 -: EXP_W];
  assign exp_b_s  = b_q[W-2 -: EXP_W];
  assign frac_a_s = a_q[FRAC_W-1:0];
  assign frac_b_s = b_q[FRAC_W-1:0];
  assign a_ez_s   = (exp_a_s == {EXP_W{1'b0}});
  assign a_eo_s   = (exp_a_s == {EXP_W{1'b1}});
  assign a_fz_s   = (frac_a_s == {FRAC_W{1'b0}});
  assign b_ez_s   = (exp_b_s == {EXP_W{1'b0}});
  assign b_eo_s   = (exp_b_s == {EXP_W{1'b1}});
  assign b_fz_s   = (frac_b_s == {FRAC_W{1'b0}});

  assign pn_s    = prod_q[2*M-1] ? prod_q : {prod_q[2*M-2:0], 1'b0};
  assign en_s    = prod_q[2*M-1] ? e_q : (e_q - ONE_E);
  assign tiny_s  = (en_s < EMIN_E);
  assign e_inc_s = e_q + ONE_E;
  assign any_s   = g_q | r_q | s_q;
  assign sum_s   = {1'b0, mant_q} + {{M{1'b0}}, inc_s};

  assign ovf_s       = (e_q > BIAS_E);
  assign exp_field_s = mant_q[M-1] ? EXP_W'(e_q + BIAS_E) : {EXP_W{1'b0}};
  assign inf_s       = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  assign max_s       = {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};

  // Round-increment decision for the selected mode.
  always_comb begin
    inc_s = 1'b0;
    case (rm_q)
      2'b00:   inc_s = g_q & (r_q | s_q | mant_q[0]);
      2'b01:   inc_s = 1'b0;
      2'b10:   inc_s = sign_q & any_s;
      2'b11:   inc_s = ~sign_q & any_s;
      default: inc_s = 1'b0;
    endcase
  end

  // Overflow result: directed modes saturate to inf only toward their direction.
  always_comb begin
    ovf_z_s = inf_s;
    case (rm_q)
      2'b00:   ovf_z_s = inf_s;
      2'b01:   ovf_z_s = max_s;
      2'b10:   ovf_z_s = sign_q ? inf_s : max_s;
      2'b11:   ovf_z_s = sign_q ? max_s : inf_s;
      default: ovf_z_s = inf_s;
    endcase
  end

  // Sequencer, datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;   in_ready_q <= 1'b1; out_valid_q <= 1'b0;
      z_q <= '0;           flags_q <= 4'b0000; a_q <= '0; b_q <= '0; rm_q <= 2'b00;
      sign_q <= 1'b0;      a_zero_q <= 1'b0; a_inf_q <= 1'b0; a_nan_q <= 1'b0;
      b_zero_q <= 1'b0;    b_inf_q <= 1'b0;  b_nan_q <= 1'b0;
      ma_q <= '0; mb_q <= '0; mant_q <= '0; ea_q <= '0; eb_q <= '0; e_q <= '0;
      prod_q <= '0; g_q <= 1'b0; r_q <= 1'b0; s_q <= 1'b0; tiny_q <= 1'b0;
      inexact_q <= 1'b0; cnt_q <= '0;
    end else if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= a; b_q <= b; rm_q <= rnd_mode;
            in_ready_q <= 1'b0;
            state_q    <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          sign_q   <= a_q[W-1] ^ b_q[W-1];
          a_zero_q <= a_ez_s & a_fz_s; a_inf_q <= a_eo_s & a_fz_s; a_nan_q <= a_eo_s & ~a_fz_s;
          b_zero_q <= b_ez_s & b_fz_s; b_inf_q <= b_eo_s & b_fz_s; b_nan_q <= b_eo_s & ~b_fz_s;
          state_q  <= S_SPECIAL;
        end
        S_SPECIAL: begin
          if (a_nan_q | b_nan_q | (a_inf_q & b_zero_q) | (a_zero_q & b_inf_q)) begin
            z_q <= QNAN; flags_q <= 4'b1000; out_valid_q <= 1'b1; state_q <= S_DONE;
          end else if (a_inf_q | b_inf_q) begin
            z_q <= inf_s; flags_q <= 4'b0000; out_valid_q <= 1'b1; state_q <= S_DONE;
          end else if (a_zero_q | b_zero_q) begin
            z_q <= {sign_q, {(W-1){1'b0}}}; flags_q <= 4'b0000;
            out_valid_q <= 1'b1; state_q <= S_DONE;
          end else begin
            ma_q <= {~a_ez_s, frac_a_s}; ea_q <= unb_exp(exp_a_s);
            mb_q <= {~b_ez_s, frac_b_s}; eb_q <= unb_exp(exp_b_s);
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          if (ma_q[M-1] & mb_q[M-1]) begin
            state_q <= S_MULT;
          end else begin
            if (!ma_q[M-1]) begin ma_q <= ma_q << 1; ea_q <= ea_q - ONE_E; end
            if (!mb_q[M-1]) begin mb_q <= mb_q << 1; eb_q <= eb_q - ONE_E; end
          end
        end
        S_MULT: begin
          prod_q  <= {{M{1'b0}}, ma_q} * {{M{1'b0}}, mb_q};
          e_q     <= ea_q + eb_q + ONE_E;
          state_q <= S_NORM_Z;
        end
        S_NORM_Z: begin
          mant_q <= pn_s[2*M-1 -: M];
          g_q    <= pn_s[M-1];
          r_q    <= pn_s[M-2];
          s_q    <= |pn_s[M-3:0];
          e_q    <= en_s;
          tiny_q <= tiny_s;
          cnt_q  <= '0;
          state_q <= tiny_s ? S_DENORM : S_ROUND;
        end
        S_DENORM: begin
          // Once every bit has reached sticky, further shifts change nothing.
          mant_q <= mant_q >> 1;
          g_q    <= mant_q[0];
          r_q    <= g_q;
          s_q    <= s_q | r_q;
          cnt_q  <= cnt_q + CW'(1);
          e_q    <= (cnt_q == CW'(LIM-1)) ? EMIN_E : e_inc_s;
          if ((cnt_q == CW'(LIM-1)) || (e_inc_s >= EMIN_E)) state_q <= S_ROUND;
        end
        S_ROUND: begin
          if (sum_s[M]) begin
            mant_q <= sum_s[M:1];
            e_q    <= e_inc_s;
          end else begin
            mant_q <= sum_s[M-1:0];
          end
          inexact_q <= any_s;
          state_q   <= S_PACK;
        end
        S_PACK: begin
          if (ovf_s) begin
            z_q <= ovf_z_s; flags_q <= 4'b0101;
          end else begin
            z_q     <= {sign_q, exp_field_s, mant_q[FRAC_W-1:0]};
            flags_q <= {2'b00, tiny_q & inexact_q, inexact_q};
          end
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0; in_ready_q <= 1'b1; state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE; in_ready_q <= 1'b1; out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign flags     = flags_q;
endmodule
